pc_gen: RTL and testbench
=========================

# pc_gen

Fetch-stage program-counter generator for the MIPS pipeline: owns the F-stage PC register and selects the next fetch address. It adds parameterised reset and exception vectors, stall-aware updating, an instruction-memory ready handshake with a held redirect, and an optional fetch-address fault check. It sits between the D-stage branch/jump resolution and the instruction memory. The exception/ERET controller (CP0) drives `req`, `eret` and `epc`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `EXC_PC`, 32'h0000_4180, exception handler entry.
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address (inclusive).
- `IMEM_HI`, 32'h0000_6FFF, highest legal fetch address (inclusive).

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hazard stall; F and D are frozen.
- `fetch_ready`  in  1  imem accepts `f_pc` this cycle.
- `req`  in  1  exception/interrupt request from CP0.
- `eret`  in  1  ERET retired; return to `epc`.
- `epc`  in  32  return address.
- `d_valid`  in  1  D-stage instruction valid; qualifies `npc_type`.
- `npc_type`  in  2  0 sequential, 1 branch, 2 j/jal, 3 jr/jalr.
- `cmp_true`  in  1  branch condition result.
- `imm32`  in  32  sign-extended branch offset (in words).
- `instr_index`  in  26  j/jal target field.
- `jr_addr`  in  32  forwarded register target.
- `d_pc`  in  32  PC of the D-stage instruction.
- `f_pc`  out  32  current fetch address (registered).
- `redirect_pending`  out  1  a redirect is held, waiting to be applied.
- `adel`  out  1  fetch address fault for `f_pc` (registered). Tied 0 unless `PC_ALIGN_CHK_EN` is defined.

## Operation
Redirect target, computed combinationally when `d_valid`:
- type 1 with `cmp_true`: `d_pc + 4 + (imm32 << 2)`, mod 2^32.
- type 2: `{d_pc[31:28], instr_index, 2'b00}`.
- type 3: `jr_addr`.
- type 0, or type 1 without `cmp_true`: no redirect.

Advance condition: `adv = fetch_ready & ~stall`.

Next-PC priority, applied at the clock edge:
1. `reset`: load `RESET_PC`.
2. `req`: load `EXC_PC` and clear pending. This case ignores `stall` and `fetch_ready`.
3. `eret` (with `~req`): load `epc` and clear pending. This case ignores `stall` and `fetch_ready`.
4. A live redirect this cycle:
   - if `adv`: load its target.
   - else: latch the target into the pending register and set `redirect_pending`. A newer redirect overwrites an older pending one.
5. `redirect_pending` and `adv`: load the pending target and clear pending.
6. `adv`: load `f_pc + 4`, mod 2^32.
7. Otherwise hold `f_pc`.

Other rules:
- Delay slot: when a branch is in D, the instruction at `f_pc` is its delay slot. The redirect replaces only the address after the slot.
- `eret` and `req` in the same cycle: `req` wins.

## Timing
- Reset values: `f_pc = RESET_PC`, `redirect_pending = 0`, `adel = 0`, pending target = 0.
- Latency: one cycle. The value selected in cycle N appears on `f_pc` in cycle N+1.
- `f_pc` is stable while `~adv`, except when `req` or `eret` is asserted.
- A held redirect is applied on the first cycle with `adv`. It is never lost and never applied twice.
- Reset asserted in the middle of a held redirect discards the pending target.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - `adel` is registered together with `f_pc`.
  - It is 1 when the loaded address has `[1:0] != 0`, or is below `IMEM_LO`, or is above `IMEM_HI`.
  - The faulting address is still loaded into `f_pc`, so CP0 can record it as BadVAddr.
  - A subsequent `req` reloads `EXC_PC` and clears `adel`.
- `PC_ALIGN_CHK_EN` not defined: `adel` is constant 0 and no range comparators are built.

## Test plan
- **Reset, then free-run.** Stimulus: `reset` 1 cycle, then `fetch_ready = 1`. Required: `f_pc` = 0x3000, then 0x3004, then 0x3008.
- **Taken branch.** Stimulus: `d_pc = 0x3004`, `imm32 = 3`, `cmp_true = 1`, `adv = 1`. Required: next `f_pc` = 0x3014. A not-taken branch instead gives `f_pc + 4`.
- **Redirect during stall.** Stimulus: type 2 with `instr_index` = 0x0000C10 and `stall = 1` for 3 cycles. Required: `f_pc` holds, `redirect_pending` = 1. One cycle after `stall` drops, `f_pc` = 0x0000_3040 and pending clears.
- **Exception priority.** Stimulus: `req`, `eret` and a jr all asserted while `stall = 1`. Required: next `f_pc` = 0x4180 and `redirect_pending` = 0. With `eret` alone and `epc` = 0x3100, `f_pc` = 0x3100.
- **Ready backpressure.** Stimulus: `fetch_ready = 0` for 2 cycles starting at `f_pc` = 0x3020. Required: `f_pc` stays 0x3020, then goes to 0x3024.
- **Fetch fault (`PC_ALIGN_CHK_EN` defined).** Stimulus: jr with `jr_addr` = 0x3002, then jr with `jr_addr` = 0x7000. Required: `f_pc` = 0x3002 with `adel` = 1, then `f_pc` = 0x7000 with `adel` = 1. With the macro not defined, `adel` stays 0 in both cases.

Source files
------------

// File: rtl/pc_gen.sv
//============================================================================
// Module   : pc_gen
// Purpose  : Fetch-stage PC register and next-fetch-address selection with
//            exception/ERET vectors, held redirects and imem backpressure.
//            Optional fetch-address fault check: define PC_ALIGN_CHK_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_valid,
  input  logic [1:0]  npc_type,
  input  logic        cmp_true,
  input  logic [31:0] imm32,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_addr,
  input  logic [31:0] d_pc,
  output logic [31:0] f_pc,
  output logic        redirect_pending,
  output logic        adel
);

  localparam logic [1:0] c_npc_seq    = 2'd0;
  localparam logic [1:0] c_npc_branch = 2'd1;
  localparam logic [1:0] c_npc_jump   = 2'd2;
  localparam logic [1:0] c_npc_jr     = 2'd3;

  logic [31:0] r_f_pc;
  logic        r_pending;
  logic [31:0] r_pend_tgt;

  logic        w_adv;
  logic        w_redir;
  logic [31:0] w_tgt;
  logic [31:0] w_next_pc;
  logic        w_next_pend;
  logic [31:0] w_next_tgt;

  assign w_adv = fetch_ready & ~stall;

  // Redirect target from the D-stage instruction; it lands after the delay slot.
  always_comb begin
    w_redir = 1'b0;
    w_tgt   = 32'h0;
    if (d_valid) begin
      case (npc_type)
        c_npc_branch: begin
          w_redir = cmp_true;
          w_tgt   = d_pc + 32'd4 + (imm32 << 2);
        end
        c_npc_jump: begin
          w_redir = 1'b1;
          w_tgt   = {d_pc[31:28], instr_index, 2'b00};
        end
        c_npc_jr: begin
          w_redir = 1'b1;
          w_tgt   = jr_addr;
        end
        c_npc_seq: w_redir = 1'b0;
        default:   w_redir = 1'b0;
      endcase
    end
  end

  // CP0 requests bypass stall/backpressure; a held redirect waits for the
  // first advancing cycle and a newer one replaces it.
  always_comb begin
    w_next_pc   = r_f_pc;
    w_next_pend = r_pending;
    w_next_tgt  = r_pend_tgt;
    if (req) begin
      w_next_pc   = EXC_PC;
      w_next_pend = 1'b0;
    end else if (eret) begin
      w_next_pc   = epc;
      w_next_pend = 1'b0;
    end else if (w_redir) begin
      if (w_adv) begin
        w_next_pc   = w_tgt;
        w_next_pend = 1'b0;
      end else begin
        w_next_pend = 1'b1;
        w_next_tgt  = w_tgt;
      end
    end else if (r_pending && w_adv) begin
      w_next_pc   = r_pend_tgt;
      w_next_pend = 1'b0;
    end else if (w_adv) begin
      w_next_pc = r_f_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc     <= RESET_PC;
      r_pending  <= 1'b0;
      r_pend_tgt <= 32'h0;
    end else begin
      r_f_pc     <= w_next_pc;
      r_pending  <= w_next_pend;
      r_pend_tgt <= w_next_tgt;
    end
  end

  assign f_pc             = r_f_pc;
  assign redirect_pending = r_pending;

`ifdef PC_ALIGN_CHK_EN
  logic r_adel;
  logic w_fault;

  // Faulting address is still loaded so CP0 can capture it as BadVAddr.
  assign w_fault = (w_next_pc[1:0] != 2'b00) || (w_next_pc < IMEM_LO) ||
                   (w_next_pc > IMEM_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_adel <= 1'b0;
    end else begin
      r_adel <= w_fault;
    end
  end

  assign adel = r_adel;
`else
  // Folds to constant 0; references the range bounds without building comparators.
  assign adel = &{1'b0, IMEM_LO[0], IMEM_HI[0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen using an expected-value queue.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, req, eret;
  logic [31:0] epc;
  logic        d_valid;
  logic [1:0]  npc_type;
  logic        cmp_true;
  logic [31:0] imm32;
  logic [25:0] instr_index;
  logic [31:0] jr_addr, d_pc;
  logic [31:0] f_pc;
  logic        redirect_pending, adel;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .req(req), .eret(eret), .epc(epc), .d_valid(d_valid), .npc_type(npc_type),
    .cmp_true(cmp_true), .imm32(imm32), .instr_index(instr_index),
    .jr_addr(jr_addr), .d_pc(d_pc), .f_pc(f_pc),
    .redirect_pending(redirect_pending), .adel(adel)
  );

  always #5 clk = ~clk;

  function automatic logic fault_of(input logic [31:0] a);
`ifdef PC_ALIGN_CHK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    reset = 0; stall = 0; fetch_ready = 1; req = 0; eret = 0; epc = 0;
    d_valid = 0; npc_type = 0; cmp_true = 0; imm32 = 0; instr_index = 0;
    jr_addr = 0; d_pc = 0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic pend);
    sb.push_back('{pc: pc, pend: pend, adel: fault_of(pc)});
  endtask

  task automatic jr(input logic [31:0] a);
    d_valid = 1; npc_type = 2'd3; jr_addr = a;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin reset = 1; push_exp(32'h3000, 0); end
        1: push_exp(32'h3004, 0);
        default: push_exp(32'h3008, 0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL reset step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin d_valid = 1; npc_type = 1; cmp_true = 1; imm32 = 3; d_pc = 32'h3004; push_exp(32'h3014, 0); end
        1: begin d_valid = 1; npc_type = 1; cmp_true = 0; imm32 = 3; d_pc = 32'h3010; push_exp(32'h3018, 0); end
        2: begin d_valid = 1; npc_type = 1; cmp_true = 1; imm32 = 32'hFFFF_FFFE; d_pc = 32'h3014; push_exp(32'h3010, 0); end
        3: push_exp(32'h3014, 0);
        4: begin d_valid = 1; npc_type = 0; jr_addr = 32'h3500; push_exp(32'h3018, 0); end
        default: begin d_valid = 0; npc_type = 3; jr_addr = 32'h3500; push_exp(32'h301C, 0); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL branch step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0, 1, 2: begin stall = 1; d_valid = 1; npc_type = 2; instr_index = 26'h0000C10; d_pc = 32'h3018; push_exp(32'h301C, 1); end
        3: push_exp(32'h3040, 0);
        4: begin stall = 1; jr(32'h3200); push_exp(32'h3040, 1); end
        5: begin stall = 1; d_valid = 1; npc_type = 2; instr_index = 26'h0000C20; d_pc = 32'h3040; push_exp(32'h3040, 1); end
        6: push_exp(32'h3080, 0);
        default: push_exp(32'h3084, 0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL redirect_stall step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_exception();
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin stall = 1; jr(32'h3300); push_exp(32'h3084, 1); end
        1: begin stall = 1; req = 1; eret = 1; epc = 32'h3100; jr(32'h3300); push_exp(32'h4180, 0); end
        2: push_exp(32'h4184, 0);
        3: begin stall = 1; eret = 1; epc = 32'h3100; push_exp(32'h3100, 0); end
        4: begin fetch_ready = 0; eret = 1; epc = 32'h3200; push_exp(32'h3200, 0); end
        default: push_exp(32'h3204, 0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL exception step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0: begin eret = 1; epc = 32'h3020; push_exp(32'h3020, 0); end
        1, 2: begin fetch_ready = 0; push_exp(32'h3020, 0); end
        3: push_exp(32'h3024, 0);
        4: begin fetch_ready = 0; jr(32'h3400); push_exp(32'h3024, 1); end
        5: begin fetch_ready = 0; push_exp(32'h3024, 1); end
        6: push_exp(32'h3400, 0);
        default: push_exp(32'h3404, 0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL backpressure step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 4; i++) begin
      idle();
      case (i)
        0: begin stall = 1; jr(32'h3500); push_exp(32'h3404, 1); end
        1: begin reset = 1; stall = 1; push_exp(32'h3000, 0); end
        2: push_exp(32'h3004, 0);
        default: push_exp(32'h3008, 0);
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL reset_pending step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin jr(32'h3002); push_exp(32'h3002, 0); end
        1: begin jr(32'h7000); push_exp(32'h7000, 0); end
        2: begin req = 1; push_exp(32'h4180, 0); end
        3: begin jr(32'h2FFC); push_exp(32'h2FFC, 0); end
        4: begin jr(32'h6FFC); push_exp(32'h6FFC, 0); end
        5: push_exp(32'h7000, 0);
        default: begin req = 1; push_exp(32'h4180, 0); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (f_pc !== e.pc || redirect_pending !== e.pend || adel !== e.adel) begin
        n_fail++;
        $display("FAIL fault step %0d: got f_pc=%h pend=%b adel=%b, expected f_pc=%h pend=%b adel=%b",
                 i, f_pc, redirect_pending, adel, e.pc, e.pend, e.adel);
      end
    end
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_redirect_stall();
    test_exception();
    test_backpressure();
    test_reset_pending();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
